// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO between the button debouncers and the LED demo; FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
// Latency: a write reaches r_data_o and the flags one cycle later; a read exposes the next head one cycle later.
// Backpressure: none; writes when full (without a read) and reads when empty are dropped.
module sync_fifo #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_i,
    input  logic                 rd_i,
    input  logic [DataWidth-1:0] w_data_i,
    output logic [DataWidth-1:0] r_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int Depth  = 1 << AddrWidth;
    localparam int CountW = AddrWidth + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]    count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 rd_acc;
    logic                 wr_acc;

    // A write into a full FIFO is only legal when the same cycle frees the head slot.
    always_comb begin
        rd_acc   = rd_i && !empty_q;
        wr_acc   = wr_i && (!full_q || rd_acc);
        wr_ptr_d = wr_ptr_q + AddrWidth'(wr_acc);
        rd_ptr_d = rd_ptr_q + AddrWidth'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CountW'(Depth));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) begin
                mem_q[wr_ptr_q] <= w_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign r_data_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_i && full_q && !rd_i) begin
                overflow_q <= 1'b1;
            end
            if (rd_i && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule
